axi4_lite_mem_responder: RTL

AXI4-Lite slave that terminates the traffic generator's master port and backs it with a small flop-based memory, so the generator's write-then-readback sweep can close on-chip without DRAM. Accepts independent write-address, write-data and read-address channels, applies byte strobes, and returns OKAY responses. An optional compile-time check returns DECERR outside its window. Sits directly downstream of the traffic generator; the generator's done/error outputs judge the pair.

---
 rtl/axi4_lite_mem_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_mem_responder.sv
//==============================================================================
// Module      : axi4_lite_mem_responder
// Description : AXI4-Lite slave backed by a flop-based memory of els_p words.
//               It terminates a traffic generator's master port so that a
//               write-then-readback sweep can complete on-chip. Byte strobes
//               are honoured, and every response is OKAY.
//               Optional macro AXIL_MEM_DECERR_EN: accesses outside
//               [base_addr_p, base_addr_p + els_p*8) return DECERR (2'b11).
//               Out-of-window writes are dropped, and out-of-window reads
//               return zero data.
// Ports       : clk_i, reset_n_i (async, active-low)
//               AW : awaddr_i, awprot_i, awvalid_i -> awready_o
//               W  : wdata_i, wstrb_i, wvalid_i    -> wready_o
//               B  : bresp_o, bvalid_o             <- bready_i
//               AR : araddr_i, arprot_i, arvalid_i -> arready_o
//               R  : rdata_o, rresp_o, rvalid_o    <- rready_i
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi4_lite_mem_responder #(
    parameter int unsigned                 addr_width_p = 28,
    parameter int unsigned                 data_width_p = 64,
    parameter int unsigned                 els_p        = 64,
    parameter logic [addr_width_p-1:0]     base_addr_p  = '0
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [addr_width_p-1:0]        awaddr_i,
    input  logic [2:0]                     awprot_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [data_width_p-1:0]        wdata_i,
    input  logic [data_width_p/8-1:0]      wstrb_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [addr_width_p-1:0]        araddr_i,
    input  logic [2:0]                     arprot_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [data_width_p-1:0]        rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rvalid_o,
    input  logic                           rready_i
);

    localparam int unsigned c_strb_w = data_width_p / 8;
    localparam int unsigned c_idx_w  = $clog2(els_p);
    localparam logic [1:0]  c_okay   = 2'b00;
    localparam logic [1:0]  c_decerr = 2'b11;

    logic                       r_en;
    logic                       r_aw_held;
    logic                       r_w_held;
    logic                       r_bvalid;
    logic                       r_rvalid;
    logic [addr_width_p-1:0]    r_awaddr;
    logic [data_width_p-1:0]    r_wdata;
    logic [c_strb_w-1:0]        r_wstrb;
    logic [1:0]                 r_bresp;
    logic [1:0]                 r_rresp;
    logic [data_width_p-1:0]    r_rdata;
    logic [data_width_p-1:0]    r_mem [els_p];

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_ar_hs;
    logic                       w_commit;
    logic [addr_width_p-1:0]    w_wr_addr;
    logic [data_width_p-1:0]    w_wr_data;
    logic [c_strb_w-1:0]        w_wr_strb;
    logic [addr_width_p-1:0]    w_wr_off;
    logic [addr_width_p-1:0]    w_rd_off;
    logic [c_idx_w-1:0]         w_wr_idx;
    logic [c_idx_w-1:0]         w_rd_idx;
    logic                       w_wr_ok;
    logic                       w_rd_ok;
    logic                       w_unused;

    assign awready_o = r_en & ~r_aw_held & ~r_bvalid;
    assign wready_o  = r_en & ~r_w_held  & ~r_bvalid;
    assign arready_o = r_en & ~r_rvalid;
    assign bvalid_o  = r_bvalid;
    assign bresp_o   = r_bresp;
    assign rvalid_o  = r_rvalid;
    assign rresp_o   = r_rresp;
    assign rdata_o   = r_rdata;

    assign w_aw_hs = awvalid_i & awready_o;
    assign w_w_hs  = wvalid_i  & wready_o;
    assign w_ar_hs = arvalid_i & arready_o;

    // A channel that has not been latched yet is taken straight from the bus,
    // so same-cycle AW/W (or completion of the second half) commits at once.
    assign w_wr_addr = r_aw_held ? r_awaddr : awaddr_i;
    assign w_wr_data = r_w_held  ? r_wdata  : wdata_i;
    assign w_wr_strb = r_w_held  ? r_wstrb  : wstrb_i;
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign w_wr_off = w_wr_addr - base_addr_p;
    assign w_rd_off = araddr_i  - base_addr_p;
    assign w_wr_idx = w_wr_off[3 +: c_idx_w];
    assign w_rd_idx = w_rd_off[3 +: c_idx_w];

`ifdef AXIL_MEM_DECERR_EN
    // One extra bit makes addresses below the base wrap to a large value,
    // so a single unsigned compare covers both ends of the window.
    localparam logic [addr_width_p:0] c_base_ext = {1'b0, base_addr_p};
    localparam logic [addr_width_p:0] c_span     = (addr_width_p + 1)'(els_p * 8);

    logic [addr_width_p:0] w_wr_rel;
    logic [addr_width_p:0] w_rd_rel;

    assign w_wr_rel = {1'b0, w_wr_addr} - c_base_ext;
    assign w_rd_rel = {1'b0, araddr_i}  - c_base_ext;
    assign w_wr_ok  = (w_wr_rel < c_span);
    assign w_rd_ok  = (w_rd_rel < c_span);
`else
    assign w_wr_ok  = 1'b1;
    assign w_rd_ok  = 1'b1;
`endif

    // Protection bits and the offset bits outside the word index carry no meaning here.
    assign w_unused = ^{awprot_i, arprot_i, w_wr_off, w_rd_off};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_en      <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? c_okay : c_decerr;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= awaddr_i;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= wdata_i;
                    r_wstrb  <= wstrb_i;
                end
                // Readies are low while a response is pending, so the
                // response can never retire in the same cycle as a commit.
                if (r_bvalid && bready_i) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_wr_ok) begin
            for (int b = 0; b < int'(c_strb_w); b++) begin
                if (w_wr_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // The read samples r_mem before this edge's write lands, so a colliding
    // read returns the old word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_okay;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_ok ? c_okay : c_decerr;
            r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        end else if (r_rvalid && rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
